// File: rtl/syn_gpu_pkg.sv
// Shared GPU types: 2D point coordinates plus point-buffer FIFO defaults.
package syn_gpu_pkg;

    localparam int P_X_W = 4;
    localparam int P_Y_W = 3;

    localparam int P_FF_X_MAX = (1 << P_X_W) - 1;
    localparam int P_FF_Y_MAX = (1 << P_Y_W) - 1;

    typedef struct packed {
        logic [P_X_W-1:0] x;
        logic [P_Y_W-1:0] y;
    } point_t;

    typedef enum logic {
        EMPTY_S  = 1'b0,
        ACTIVE_S = 1'b1
    } ff_state_t;

endpackage

// File: rtl/syn_gpu_ff_cntrlr_intf.sv
// Handshake between the GPU master and the point-buffer FIFO controller.
interface syn_gpu_ff_cntrlr_intf
    import syn_gpu_pkg::*;
    ;
    logic   wr_en;
    logic   rd_en;
    logic   empty;
    logic   full;
    point_t waddr;
    point_t raddr;

    modport master (
        output wr_en,
        output rd_en,
        input  empty,
        input  full,
        input  waddr,
        input  raddr
    );

    modport cntrlr (
        input  wr_en,
        input  rd_en,
        output empty,
        output full,
        output waddr,
        output raddr
    );
endinterface

// File: rtl/syn_gpu_pt_incr.sv
// Combinational raster-order increment of a point, wrapping at (X_MAX, Y_MAX).
module syn_gpu_pt_incr
    import syn_gpu_pkg::*;
#(
    parameter int WIDTHX = P_X_W,
    parameter int WIDTHY = P_Y_W,
    parameter int X_MAX  = (1 << WIDTHX) - 1,
    parameter int Y_MAX  = (1 << WIDTHY) - 1
) (
    input  point_t pt,
    output point_t nxt
);
    localparam logic [WIDTHX-1:0] X_LAST = WIDTHX'(X_MAX);
    localparam logic [WIDTHY-1:0] Y_LAST = WIDTHY'(Y_MAX);
    localparam logic [WIDTHX-1:0] X_ONE  = WIDTHX'(1);
    localparam logic [WIDTHY-1:0] Y_ONE  = WIDTHY'(1);

    always_comb begin
        nxt = pt;
        if (pt.x == X_LAST) begin
            nxt.x = '0;
            nxt.y = (pt.y == Y_LAST) ? '0 : pt.y + Y_ONE;
        end else begin
            nxt.x = pt.x + X_ONE;
        end
    end
endmodule

// File: rtl/syn_gpu_ff_cntrlr.sv
// Point-buffer FIFO controller: 2D circular read/write pointers, occupancy,
// empty/full flags and overflow/underflow pulses, all registered.
module syn_gpu_ff_cntrlr
    import syn_gpu_pkg::*;
#(
    parameter int  WIDTHX = P_X_W,
    parameter int  WIDTHY = P_Y_W,
    parameter int  X_MAX  = (1 << WIDTHX) - 1,
    parameter int  Y_MAX  = (1 << WIDTHY) - 1,
    localparam int CAP    = (X_MAX + 1) * (Y_MAX + 1),
    localparam int OCC_W  = $clog2(CAP + 1)
) (
    input  logic                        clk_ir,
    input  logic                        rst_il,
    syn_gpu_ff_cntrlr_intf.cntrlr       cntrlr_intf,
    input  logic                        clr_ip,
    output logic [OCC_W-1:0]            occ_od,
    output logic                        ovrflw_op,
    output logic                        undrflw_op
);
    localparam logic [OCC_W-1:0] OCC_CAP = OCC_W'(CAP);

    ff_state_t        state_q, state_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    point_t           waddr_q, waddr_d, waddr_inc;
    point_t           raddr_q, raddr_d, raddr_inc;
    logic             full_q, full_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic             wr_acc, rd_acc;

    syn_gpu_pt_incr #(
        .WIDTHX (WIDTHX),
        .WIDTHY (WIDTHY),
        .X_MAX  (X_MAX),
        .Y_MAX  (Y_MAX)
    ) u_wincr (
        .pt  (waddr_q),
        .nxt (waddr_inc)
    );

    syn_gpu_pt_incr #(
        .WIDTHX (WIDTHX),
        .WIDTHY (WIDTHY),
        .X_MAX  (X_MAX),
        .Y_MAX  (Y_MAX)
    ) u_rincr (
        .pt  (raddr_q),
        .nxt (raddr_inc)
    );

    // A read frees a slot in the same cycle, so a full FIFO still accepts a write alongside it.
    assign wr_acc = cntrlr_intf.wr_en & (~full_q | cntrlr_intf.rd_en);
    assign rd_acc = cntrlr_intf.rd_en & (state_q == ACTIVE_S);

    always_comb begin
        state_d = state_q;
        occ_d   = occ_q;
        waddr_d = waddr_q;
        raddr_d = raddr_q;
        full_d  = full_q;
        ovf_d   = 1'b0;
        udf_d   = 1'b0;
        if (clr_ip) begin
            state_d = EMPTY_S;
            occ_d   = '0;
            waddr_d = '0;
            raddr_d = '0;
            full_d  = 1'b0;
        end else begin
            if (wr_acc) waddr_d = waddr_inc;
            if (rd_acc) raddr_d = raddr_inc;
            occ_d   = occ_q + OCC_W'(wr_acc) - OCC_W'(rd_acc);
            state_d = (occ_d == '0) ? EMPTY_S : ACTIVE_S;
            full_d  = (occ_d == OCC_CAP);
            ovf_d   = cntrlr_intf.wr_en & ~wr_acc;
            udf_d   = cntrlr_intf.rd_en & ~rd_acc;
        end
    end

    always_ff @(posedge clk_ir or posedge rst_il) begin
        if (rst_il) begin
            state_q <= EMPTY_S;
            occ_q   <= '0;
            waddr_q <= '0;
            raddr_q <= '0;
            full_q  <= 1'b0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            occ_q   <= occ_d;
            waddr_q <= waddr_d;
            raddr_q <= raddr_d;
            full_q  <= full_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    assign cntrlr_intf.empty = (state_q == EMPTY_S);
    assign cntrlr_intf.full  = full_q;
    assign cntrlr_intf.waddr = waddr_q;
    assign cntrlr_intf.raddr = raddr_q;
    assign occ_od            = occ_q;
    assign ovrflw_op         = ovf_q;
    assign undrflw_op        = udf_q;
endmodule

// File: tb/tb_syn_gpu_ff_cntrlr.sv
// Bench for syn_gpu_ff_cntrlr with a 4x2 point buffer (CAP = 8).
module tb_syn_gpu_ff_cntrlr;
    import syn_gpu_pkg::*;

    localparam int XM  = 3;
    localparam int YM  = 1;
    localparam int CAP = (XM + 1) * (YM + 1);

    logic       clk;
    logic       rst;
    logic       clr;
    logic [3:0] occ;
    logic       ovf;
    logic       udf;

    int n_chk = 0;
    int n_err = 0;

    // reference model: counts of accepted pushes/pops folded into slot indices
    int m_occ, m_widx, m_ridx;
    bit m_ovf, m_udf;

    syn_gpu_ff_cntrlr_intf ff_if ();

    syn_gpu_ff_cntrlr #(
        .X_MAX (XM),
        .Y_MAX (YM)
    ) dut (
        .clk_ir      (clk),
        .rst_il      (rst),
        .cntrlr_intf (ff_if.cntrlr),
        .clr_ip      (clr),
        .occ_od      (occ),
        .ovrflw_op   (ovf),
        .undrflw_op  (udf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit wr, rd, cl;
        int occ, wx, wy, rx, ry;
        bit full, empty, ovf, udf;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input int e_occ, input int wx, input int wy,
                           input int rx, input int ry, input bit e_full, input bit e_empty,
                           input bit e_ovf, input bit e_udf);
        chk({tag, ".occ"},   32'(occ),              32'(e_occ));
        chk({tag, ".waddr"}, {ff_if.waddr.x, ff_if.waddr.y}, {wx[3:0], wy[2:0]});
        chk({tag, ".raddr"}, {ff_if.raddr.x, ff_if.raddr.y}, {rx[3:0], ry[2:0]});
        chk({tag, ".full"},  32'(ff_if.full),       32'(e_full));
        chk({tag, ".empty"}, 32'(ff_if.empty),      32'(e_empty));
        chk({tag, ".ovf"},   32'(ovf),              32'(e_ovf));
        chk({tag, ".udf"},   32'(udf),              32'(e_udf));
    endtask

    task automatic model_reset();
        m_occ = 0; m_widx = 0; m_ridx = 0; m_ovf = 0; m_udf = 0;
    endtask

    task automatic model_step(input bit wr, input bit rd, input bit cl);
        bit wa, ra;
        if (cl) begin
            model_reset();
        end else begin
            wa = wr && (m_occ < CAP || rd);
            ra = rd && (m_occ > 0);
            m_occ  = m_occ + int'(wa) - int'(ra);
            m_widx = (m_widx + int'(wa)) % CAP;
            m_ridx = (m_ridx + int'(ra)) % CAP;
            m_ovf  = wr && !wa;
            m_udf  = rd && !ra;
        end
    endtask

    task automatic chk_model(input string tag);
        chk_all(tag, m_occ, m_widx % (XM + 1), m_widx / (XM + 1),
                m_ridx % (XM + 1), m_ridx / (XM + 1),
                m_occ == CAP, m_occ == 0, m_ovf, m_udf);
    endtask

    task automatic step(input bit wr, input bit rd, input bit cl);
        @(negedge clk);
        ff_if.wr_en = wr;
        ff_if.rd_en = rd;
        clr = cl;
        @(posedge clk);
        model_step(wr, rd, cl);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        ff_if.wr_en = 1'b0;
        ff_if.rd_en = 1'b0;
        clr = 1'b0;
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    vec_t tbl[$];

    initial begin
        rst = 1'b1;
        clr = 1'b0;
        ff_if.wr_en = 1'b0;
        ff_if.rd_en = 1'b0;
        model_reset();

        //               wr rd cl occ wx wy rx ry full empty ovf udf
        tbl.push_back('{1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{1, 0, 0, 2, 2, 0, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{1, 0, 0, 3, 3, 0, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{1, 0, 0, 4, 0, 1, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{1, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{1, 0, 0, 6, 2, 1, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{1, 0, 0, 7, 3, 1, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{1, 0, 0, 8, 0, 0, 0, 0, 1, 0, 0, 0});
        tbl.push_back('{1, 0, 0, 8, 0, 0, 0, 0, 1, 0, 1, 0});
        tbl.push_back('{0, 0, 0, 8, 0, 0, 0, 0, 1, 0, 0, 0});
        tbl.push_back('{1, 1, 0, 8, 1, 0, 1, 0, 1, 0, 0, 0});
        tbl.push_back('{0, 1, 0, 7, 1, 0, 2, 0, 0, 0, 0, 0});
        tbl.push_back('{1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0});
        tbl.push_back('{0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1});
        tbl.push_back('{1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1});
        tbl.push_back('{0, 1, 0, 0, 1, 0, 1, 0, 0, 1, 0, 0});

        #2;
        chk_all("reset_async", 0, 0, 0, 0, 0, 0, 1, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        chk_all("reset_idle", 0, 0, 0, 0, 0, 0, 1, 0, 0);

        foreach (tbl[i]) begin
            step(tbl[i].wr, tbl[i].rd, tbl[i].cl);
            chk_all($sformatf("vec%0d", i), tbl[i].occ, tbl[i].wx, tbl[i].wy,
                    tbl[i].rx, tbl[i].ry, tbl[i].full, tbl[i].empty,
                    tbl[i].ovf, tbl[i].udf);
        end

        // fill to 5 then flush with a write in the same cycle
        do_reset();
        for (int i = 0; i < 5; i++) step(1, 0, 0);
        chk_all("fill5", 5, 1, 1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 1);
        chk_all("clr_wr", 0, 0, 0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0);
        chk_all("clr_after", 0, 0, 0, 0, 0, 0, 1, 0, 0);

        // reset asserted between edges mid-burst must clear state immediately
        for (int i = 0; i < 3; i++) step(1, i[0], 0);
        #2;
        rst = 1'b1;
        #1;
        chk_all("rst_midburst", 0, 0, 0, 0, 0, 0, 1, 0, 0);
        @(negedge clk);
        ff_if.wr_en = 1'b0;
        ff_if.rd_en = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        // randomized phases: fill-heavy, drain-heavy, balanced
        for (int i = 0; i < 600; i++) begin
            int  ph;
            bit  w, r, c;
            ph = (i / 40) % 3;
            case (ph)
                0:       begin w = ($urandom_range(0, 9) < 8); r = ($urandom_range(0, 9) < 2); end
                1:       begin w = ($urandom_range(0, 9) < 2); r = ($urandom_range(0, 9) < 8); end
                default: begin w = $urandom_range(0, 1) != 0;  r = $urandom_range(0, 1) != 0;  end
            endcase
            c = ($urandom_range(0, 63) == 0);
            step(w, r, c);
            chk_model($sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/syn_gpu_ff_cntrlr.md
Name: syn_gpu_ff_cntrlr

Overview:
- Responder end of the syn_gpu_ff_cntrlr_intf protocol: the FIFO controller that the GPU master drives via the master modport.
- Keeps circular write and read pointers as 2D point_t coordinates into a rectangular point-buffer RAM (X_MAX+1 columns by Y_MAX+1 rows).
- Tracks occupancy and flags empty/full.
- Sits beside the point-buffer RAM in the grapheme GPU. The master uses waddr/raddr directly as RAM addresses.

Parameters:
- WIDTHX, syn_gpu_pkg::P_X_W, width of the point_t x field.
- WIDTHY, syn_gpu_pkg::P_Y_W, width of the point_t y field.
- X_MAX, (1<<WIDTHX)-1, last column used; must be ≤ 2^WIDTHX-1.
- Y_MAX, (1<<WIDTHY)-1, last row used; must be ≤ 2^WIDTHY-1.
- Derived: CAP = (X_MAX+1)*(Y_MAX+1); OCC_W = $clog2(CAP+1).

Ports:
- clk_ir  input  1  clock; all logic on the rising edge.
- rst_il  input  1  reset, asynchronous, active-high.
- cntrlr_intf  modport  -  syn_gpu_ff_cntrlr_intf.cntrlr. Carries the next six signals.
- wr_en  input  1  push request; RAM write at waddr in the same cycle.
- rd_en  input  1  pop request; the entry at raddr is consumed.
- empty  output  1  occupancy == 0.
- full  output  1  occupancy == CAP.
- waddr  output  point_t  next write location.
- raddr  output  point_t  oldest valid entry / next read location.
- clr_ip  input  1  synchronous flush.
- occ_od  output  OCC_W  current occupancy.
- ovrflw_op  output  1  one-cycle pulse: wr_en rejected because full.
- undrflw_op  output  1  one-cycle pulse: rd_en rejected because empty.

Behaviour:
- Reset (async assert, sync deassert by the design convention):
  - waddr = raddr = {x:0, y:0}; occ_od = 0; empty = 1; full = 0; ovrflw_op = undrflw_op = 0.
- All outputs are registered. Pointer, occupancy and flag updates are visible one cycle after the accepted request.
- Acceptance rules:
  - wr_acc = wr_en & (~full | rd_en).
  - rd_acc = rd_en & ~empty.
- Full case: wr_en and rd_en together while full → both accepted (pass-through). occ stays CAP; both pointers advance.
- Empty case: wr_en and rd_en together while empty → only the write is accepted. occ becomes 1; undrflw_op pulses.
- Pointer advance (applies to waddr on wr_acc, raddr on rd_acc):
  - if x == X_MAX: x ← 0 and y ← (y == Y_MAX ? 0 : y+1);
  - else x ← x+1.
- Occupancy update: occ ← occ + wr_acc − rd_acc.
- Flags: empty and full are computed from the next occ value and registered, so there is no extra lag.
- Error pulses, each lasting one cycle after the offending request:
  - ovrflw_op = wr_en & ~wr_acc.
  - undrflw_op = rd_en & ~rd_acc.
- clr_ip has priority over wr_en/rd_en. Next cycle, all state returns to reset values, and requests in the clr cycle are ignored with no error pulses.
- Reset mid-operation: state is discarded immediately. The master must not rely on RAM contents after reset.
- Two internal states (EMPTY_S, ACTIVE_S) drive empty; full is derived from occ == CAP. No other states.

Decomposition:
- syn_gpu_pkg already holds point_t, P_X_W and P_Y_W. Add P_FF_X_MAX and P_FF_Y_MAX defaults there.
- One sub-module, syn_gpu_pt_incr. It is a combinational point_t wrap-increment parameterised by X_MAX/Y_MAX and instantiated twice, once for waddr and once for raddr.

Test Plan:
All scenarios use X_MAX=3, Y_MAX=1 (CAP=8).
- Reset → empty=1, full=0, occ=0, waddr=raddr=(0,0); assert rst_il mid-burst → same values immediately.
- 8 consecutive writes → waddr steps (1,0),(2,0),(3,0),(0,1)…(3,1), then (0,0); full=1 and occ=8 the cycle after the 8th write.
- Write while full, rd_en=0 → ovrflw_op pulses once; waddr and occ are unchanged.
- Write+read together while full → occ stays 8, full stays 1, both pointers advance by one.
- Read while empty → undrflw_op pulses. Write+read together while empty → occ=1, waddr=(1,0), raddr=(0,0), undrflw_op=1.
- Fill to 5, then assert clr_ip with wr_en=1 → next cycle occ=0, empty=1, pointers=(0,0), no ovrflw/undrflw pulses.
